// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780-style text driver: FSM encodings,
// controller command bytes and small byte-selection helpers.
package lcd_pkg;

    typedef enum logic [2:0] {
        ST_POWERUP,
        ST_INIT,
        ST_IDLE,
        ST_ADDR1,
        ST_LINE1,
        ST_ADDR2,
        ST_LINE2
    } lcd_state_e;

    typedef enum logic [1:0] {
        PH_IDLE,
        PH_SETUP,
        PH_ENABLE,
        PH_WAIT
    } wr_phase_e;

    localparam logic [7:0] CMD_FUNCTION_SET = 8'h38;  // 8-bit bus, 2 lines, 5x8 font
    localparam logic [7:0] CMD_DISPLAY_ON   = 8'h0C;
    localparam logic [7:0] CMD_ENTRY_MODE   = 8'h06;
    localparam logic [7:0] CMD_CLEAR        = 8'h01;
    localparam logic [7:0] CMD_LINE1_ADDR   = 8'h80;
    localparam logic [7:0] CMD_LINE2_ADDR   = 8'hC0;

    localparam int INIT_LEN = 4;

    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        logic [7:0] cmd;
        case (idx)
            2'd0:    cmd = CMD_FUNCTION_SET;
            2'd1:    cmd = CMD_DISPLAY_ON;
            2'd2:    cmd = CMD_ENTRY_MODE;
            default: cmd = CMD_CLEAR;
        endcase
        return cmd;
    endfunction

    // Character idx counts from the left; the leftmost char sits in the top byte.
    function automatic logic [7:0] char_at(input logic [127:0] line, input logic [3:0] idx);
        logic [127:0] shifted;
        shifted = line << {idx, 3'b000};
        return shifted[127:120];
    endfunction

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/lcd_byte_writer.sv
// Sends one byte on the LCD bus: one setup cycle, EN_CYC cycles with enable
// high, then a post-byte wait (long when long_wait was set at start).
module lcd_byte_writer
    import lcd_pkg::*;
#(
    parameter int EN_CYC         = 25,
    parameter int WAIT_CYC       = 2500,
    parameter int CLEAR_WAIT_CYC = 100000,
    parameter int CNT_W          = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       regsel,
    input  logic [7:0] data,
    input  logic       long_wait,
    output logic       busy,
    output logic       done,
    output logic       lcd_regsel,
    output logic       lcd_enable,
    output logic [7:0] lcd_data
);

    localparam logic [CNT_W-1:0] EN_LAST    = CNT_W'(EN_CYC - 1);
    localparam logic [CNT_W-1:0] WAIT_LAST  = CNT_W'(WAIT_CYC - 1);
    localparam logic [CNT_W-1:0] CLEAR_LAST = CNT_W'(CLEAR_WAIT_CYC - 1);

    wr_phase_e        phase_q, phase_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             regsel_q, regsel_d;
    logic [7:0]       data_q, data_d;
    logic             long_q, long_d;
    logic [CNT_W-1:0] wait_last;

    // NOTE: sequential state uses non-blocking assignments only; the async
    // clear is what drops lcd_enable the moment reset rises.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_q  <= PH_IDLE;
            cnt_q    <= '0;
            regsel_q <= 1'b0;
            data_q   <= 8'h00;
            long_q   <= 1'b0;
        end else begin
            phase_q  <= phase_d;
            cnt_q    <= cnt_d;
            regsel_q <= regsel_d;
            data_q   <= data_d;
            long_q   <= long_d;
        end
    end

    assign wait_last = long_q ? CLEAR_LAST : WAIT_LAST;
    assign done      = (phase_q == PH_WAIT) && (cnt_q == wait_last);

    // NOTE: every variable gets a default first so no latch is inferred.
    always_comb begin
        phase_d  = phase_q;
        cnt_d    = cnt_q;
        regsel_d = regsel_q;
        data_d   = data_q;
        long_d   = long_q;
        case (phase_q)
            PH_SETUP: begin
                phase_d = PH_ENABLE;
                cnt_d   = '0;
            end
            PH_ENABLE: begin
                if (cnt_q == EN_LAST) begin
                    phase_d = PH_WAIT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            PH_WAIT: begin
                if (done) begin
                    phase_d = PH_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: ;
        endcase
        // A start in the final wait cycle chains bytes with no idle gap.
        if (start) begin
            phase_d  = PH_SETUP;
            cnt_d    = '0;
            regsel_d = regsel;
            data_d   = data;
            long_d   = long_wait;
        end
    end

    assign busy       = (phase_q != PH_IDLE);
    assign lcd_enable = (phase_q == PH_ENABLE);
    assign lcd_regsel = regsel_q;
    assign lcd_data   = data_q;

endmodule

// File: rtl/lcd_text_driver.sv
// Two-line 16x2 text driver: power-up wait, controller init, then on print
// writes both latched lines through lcd_byte_writer.
module lcd_text_driver
    import lcd_pkg::*;
#(
    parameter int POWERUP_CYC    = 750000,
    parameter int EN_CYC         = 25,
    parameter int WAIT_CYC       = 2500,
    parameter int CLEAR_WAIT_CYC = 100000
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         print,
    input  logic [127:0] topline,
    input  logic [127:0] bottomline,
    output logic         available,
    output logic         lcd_regsel,
    output logic         lcd_read,
    output logic         lcd_enable,
    output logic [7:0]   lcd_data
);

    localparam int CNT_W = $clog2(max4(POWERUP_CYC, EN_CYC, WAIT_CYC, CLEAR_WAIT_CYC) + 1);
    localparam logic [CNT_W-1:0] PU_LAST = CNT_W'(POWERUP_CYC - 1);

    lcd_state_e       state_q, state_d;
    logic [CNT_W-1:0] pu_cnt_q, pu_cnt_d;
    logic [1:0]       init_idx_q, init_idx_d;
    logic [3:0]       idx_q, idx_d;
    logic [127:0]     top_q, top_d;
    logic [127:0]     bot_q, bot_d;

    logic       launch;
    logic       wr_regsel;
    logic [7:0] wr_data;
    logic       wr_long;
    logic       wr_busy;
    logic       wr_done;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_POWERUP;
            pu_cnt_q   <= '0;
            init_idx_q <= '0;
            idx_q      <= '0;
            top_q      <= '0;
            bot_q      <= '0;
        end else begin
            state_q    <= state_d;
            pu_cnt_q   <= pu_cnt_d;
            init_idx_q <= init_idx_d;
            idx_q      <= idx_d;
            top_q      <= top_d;
            bot_q      <= bot_d;
        end
    end

    // Position advances on writer done; launch starts the next byte in that
    // same cycle so back-to-back bytes have no gap.
    always_comb begin
        state_d    = state_q;
        pu_cnt_d   = pu_cnt_q;
        init_idx_d = init_idx_q;
        idx_d      = idx_q;
        top_d      = top_q;
        bot_d      = bot_q;
        launch     = 1'b0;
        case (state_q)
            ST_POWERUP: begin
                if (pu_cnt_q == PU_LAST) begin
                    state_d    = ST_INIT;
                    pu_cnt_d   = '0;
                    init_idx_d = '0;
                    launch     = 1'b1;
                end else begin
                    pu_cnt_d = pu_cnt_q + 1'b1;
                end
            end
            ST_INIT: begin
                if (wr_done) begin
                    if (init_idx_q == 2'(INIT_LEN - 1)) begin
                        state_d    = ST_IDLE;
                        init_idx_d = '0;
                    end else begin
                        init_idx_d = init_idx_q + 1'b1;
                        launch     = 1'b1;
                    end
                end
            end
            ST_IDLE: begin
                if (print && !wr_busy) begin
                    state_d = ST_ADDR1;
                    top_d   = topline;
                    bot_d   = bottomline;
                    launch  = 1'b1;
                end
            end
            ST_ADDR1: begin
                if (wr_done) begin
                    state_d = ST_LINE1;
                    idx_d   = '0;
                    launch  = 1'b1;
                end
            end
            ST_LINE1: begin
                if (wr_done) begin
                    if (idx_q == 4'd15) begin
                        state_d = ST_ADDR2;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                    launch = 1'b1;
                end
            end
            ST_ADDR2: begin
                if (wr_done) begin
                    state_d = ST_LINE2;
                    idx_d   = '0;
                    launch  = 1'b1;
                end
            end
            ST_LINE2: begin
                if (wr_done) begin
                    if (idx_q == 4'd15) begin
                        state_d = ST_IDLE;
                        idx_d   = '0;
                    end else begin
                        idx_d  = idx_q + 1'b1;
                        launch = 1'b1;
                    end
                end
            end
            default: state_d = ST_POWERUP;
        endcase
    end

    // The byte offered to the writer belongs to the position being entered.
    always_comb begin
        available = (state_q == ST_IDLE);
        wr_regsel = 1'b0;
        wr_data   = 8'h00;
        wr_long   = 1'b0;
        case (state_d)
            ST_INIT: begin
                wr_data = init_cmd(init_idx_d);
                wr_long = (init_cmd(init_idx_d) == CMD_CLEAR);
            end
            ST_ADDR1: wr_data = CMD_LINE1_ADDR;
            ST_LINE1: begin
                wr_regsel = 1'b1;
                wr_data   = char_at(top_q, idx_d);
            end
            ST_ADDR2: wr_data = CMD_LINE2_ADDR;
            ST_LINE2: begin
                wr_regsel = 1'b1;
                wr_data   = char_at(bot_q, idx_d);
            end
            default: ;
        endcase
    end

    lcd_byte_writer #(
        .EN_CYC        (EN_CYC),
        .WAIT_CYC      (WAIT_CYC),
        .CLEAR_WAIT_CYC(CLEAR_WAIT_CYC),
        .CNT_W         (CNT_W)
    ) u_writer (
        .clk       (clk),
        .reset     (reset),
        .start     (launch),
        .regsel    (wr_regsel),
        .data      (wr_data),
        .long_wait (wr_long),
        .busy      (wr_busy),
        .done      (wr_done),
        .lcd_regsel(lcd_regsel),
        .lcd_enable(lcd_enable),
        .lcd_data  (lcd_data)
    );

    assign lcd_read = 1'b0;

endmodule
